// File: rtl/pwm_dac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_dac_pkg                                                          |
// | Mode encodings and signed-to-offset-binary conversion for the DAC.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pwm_dac_pkg;

    localparam logic MODE_PWM  = 1'b0;
    localparam logic MODE_SD   = 1'b1;
    localparam int   MAX_WIDTH = 16;

    // Flipping the sign bit maps two's complement onto offset binary.
    function automatic logic [MAX_WIDTH-1:0] to_offset(
        input logic [MAX_WIDTH-1:0] sample,
        input int                   width
    );
        return sample ^ (MAX_WIDTH'(1) << (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_dac_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_dac_ch                                                           |
// | One DAC channel: active sample, PWM comparator, sigma-delta loop.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pwm_dac_ch
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] cnt,
    input  logic             mode_sd,
    input  logic             acc_clr,
    output logic             dac_out
);

    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    assign u   = WIDTH'(to_offset(MAX_WIDTH'(active), WIDTH));
    // The accumulator's carry bit is consumed the same cycle it is produced,
    // so only the residue is stored; the carry itself is the registered output.
    assign sum = {1'b0, acc} + {1'b0, u};

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= '0;
            acc     <= '0;
            dac_out <= 1'b0;
        end else begin
            if (load) begin
                active <= load_value;
            end
            if (cen) begin
                if (mode_sd) begin
                    dac_out <= sum[WIDTH];
                    acc     <= sum[WIDTH-1:0];
                end else begin
                    dac_out <= (cnt < u);
                end
                if (acc_clr) begin
                    acc <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_dac_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_dac_multi                                                        |
// | Multi-channel PWM / sigma-delta DAC with double-buffered samples.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pwm_dac_multi
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cen,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] sample_in,
    input  logic                      sample_valid,
    input  logic                      clr_ovr,
    output logic [CHANNELS-1:0]       dac_out,
    output logic                      period_start,
    output logic                      overrun
);

    logic [WIDTH-1:0]          cnt;
    logic [CHANNELS*WIDTH-1:0] pending;
    logic [CHANNELS*WIDTH-1:0] next_active;
    logic                      pending_full;
    logic                      mode_latched;
    logic                      wrap;
    logic                      acc_clr;
    logic                      overrun_set;

    assign wrap        = cen && (cnt == {WIDTH{1'b1}});
    assign next_active = (sample_valid && wrap) ? sample_in : pending;
    assign acc_clr     = wrap && (mode != mode_latched);
    assign overrun_set = sample_valid && pending_full && !wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cen) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // Pending tracks whatever went active so a later idle wrap reloads it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (wrap) begin
            pending      <= next_active;
            pending_full <= 1'b0;
        end else if (sample_valid) begin
            pending      <= sample_in;
            pending_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun      <= 1'b0;
            mode_latched <= MODE_PWM;
            period_start <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
            if (wrap) begin
                mode_latched <= mode;
            end
            period_start <= wrap;
        end
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            pwm_dac_ch #(
                .WIDTH (WIDTH)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .cen        (cen),
                .load       (wrap),
                .load_value (next_active[k*WIDTH +: WIDTH]),
                .cnt        (cnt),
                .mode_sd    (mode_latched == MODE_SD),
                .acc_clr    (acc_clr),
                .dac_out    (dac_out[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_dac_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pwm_dac_multi                                                     |
// | Self-checking bench: behavioural model plus directed/random stimulus.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pwm_dac_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        mode = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        clr_ovr = 1'b0;
    logic [1:0]  dac_out;
    logic        period_start;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    pwm_dac_multi #(.WIDTH(8), .CHANNELS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cen          (cen),
        .mode         (mode),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clr_ovr      (clr_ovr),
        .dac_out      (dac_out),
        .period_start (period_start),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: samples held as signed integers, u = sample + 128.
    int m_cnt, m_full, m_ovr, m_mode, m_ps;
    int m_act[2], m_pend[2], m_acc[2], m_out[2];
    int t_u, t_s, t_smp, t_nv;
    bit t_wrap;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_full = 0; m_ovr = 0; m_mode = 0; m_ps = 0;
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 0; m_pend[k] = 0; m_acc[k] = 0; m_out[k] = 0;
            end
        end else begin
            t_wrap = cen && (m_cnt == 255);
            for (int k = 0; k < 2; k++) begin
                t_u = m_act[k] + 128;
                if (cen) begin
                    if (m_mode == 1) begin
                        t_s = m_acc[k] + t_u;
                        m_out[k] = (t_s >= 256) ? 1 : 0;
                        m_acc[k] = t_s % 256;
                    end else begin
                        m_out[k] = (m_cnt < t_u) ? 1 : 0;
                    end
                    if (t_wrap && (int'(mode) != m_mode)) m_acc[k] = 0;
                end
            end
            if (sample_valid && m_full == 1 && !t_wrap) m_ovr = 1;
            else if (clr_ovr) m_ovr = 0;
            for (int k = 0; k < 2; k++) begin
                t_smp = int'($signed(sample_in[k*8 +: 8]));
                if (t_wrap) begin
                    t_nv = sample_valid ? t_smp : m_pend[k];
                    m_act[k]  = t_nv;
                    m_pend[k] = t_nv;
                end else if (sample_valid) begin
                    m_pend[k] = t_smp;
                end
            end
            if (t_wrap) m_full = 0;
            else if (sample_valid) m_full = 1;
            m_ps = t_wrap ? 1 : 0;
            if (t_wrap) m_mode = int'(mode);
            if (cen) m_cnt = (m_cnt + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("dac_out[0]", int'(dac_out[0]), m_out[0]);
            check("dac_out[1]", int'(dac_out[1]), m_out[1]);
            check("period_start", int'(period_start), m_ps);
            check("overrun", int'(overrun), m_ovr);
        end
    end

    task automatic set_samples(input int s0, input int s1);
        sample_in = {8'(s1), 8'(s0)};
    endtask

    task automatic strobe(input int s0, input int s1);
        set_samples(s0, s1);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_pstart();
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (period_start) break;
        end
        if (i == 2000) check("period_start_timeout", 0, 1);
    endtask

    task automatic count_ones(input int k, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c += int'(dac_out[k]);
        end
    endtask

    initial begin
        int c0, c1, t0, t1, found, holds, prev_dac, prev_cen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state: mid-scale on ch0, no overrun
        check("reset_overrun", int'(overrun), 0);
        wait_pstart();
        count_ones(0, 256, c0);
        check("reset_ch0_ones", c0, 128);

        // PWM extremes
        strobe(-128, 127);
        wait_pstart();
        count_ones(0, 1, c0);
        check("pwm_min_first", c0, 0);
        check("pwm_max_first", int'(dac_out[1]), 1);
        count_ones(1, 255, c1);
        check("pwm_max_ch1_ones", c1 + 1, 255);
        count_ones(0, 256, c0);
        check("pwm_min_ch0_ones", c0, 0);

        // Overrun: two strobes in one period, second applies
        strobe(10, 20);
        strobe(64, -64);
        check("overrun_set", int'(overrun), 1);
        wait_pstart();
        fork
            count_ones(0, 256, c0);
            count_ones(1, 256, c1);
        join
        check("overrun_second_ch0", c0, 192);
        check("overrun_second_ch1", c1, 64);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("overrun_cleared", int'(overrun), 0);

        // Strobe coinciding with the wrap cycle
        for (int i = 0; i < 600 && m_cnt != 255; i++) @(negedge clk);
        strobe(-96, 100);
        check("wrap_pstart", int'(period_start), 1);
        check("wrap_overrun", int'(overrun), 0);
        fork
            count_ones(0, 256, c0);
            count_ones(1, 256, c1);
        join
        check("wrap_ch0_ones", c0, 32);
        check("wrap_ch1_ones", c1, 228);

        // Sigma-delta with u=192; pattern 0,1,1,1 from a cleared accumulator
        mode = 1'b1;
        strobe(64, 64);
        wait_pstart();
        count_ones(0, 1, c0); check("sd_bit0", c0, 0);
        count_ones(0, 1, c0); check("sd_bit1", c0, 1);
        count_ones(0, 1, c0); check("sd_bit2", c0, 1);
        count_ones(0, 1, c0); check("sd_bit3", c0, 1);
        count_ones(0, 256, c0);
        check("sd_ones", c0, 192);
        mode = 1'b0;
        @(negedge clk);
        check("mode_mid_period_held_sd", m_mode, 1);
        wait_pstart();
        count_ones(0, 1, c0);
        check("pwm_back_first", c0, 1);

        // cen toggling stretches the period and freezes the outputs
        found = 0; t0 = 0; t1 = 0; holds = 0;
        prev_dac = int'(dac_out); prev_cen = 1;
        for (int i = 0; i < 1600 && found < 2; i++) begin
            @(negedge clk);
            if (prev_cen == 0 && int'(dac_out) != prev_dac) holds++;
            if (period_start) begin
                if (found == 0) t0 = i; else t1 = i;
                found++;
            end
            prev_dac = int'(dac_out);
            cen = ~cen;
            prev_cen = int'(cen);
        end
        check("cen_two_pstarts", found, 2);
        check("cen_period_clks", t1 - t0, 512);
        check("cen_hold_violations", holds, 0);
        cen = 1'b1;

        // Randomized traffic against the model, including mid-period resets
        for (int i = 0; i < 4000; i++) begin
            cen          = ($urandom_range(0, 3) != 0);
            sample_valid = ($urandom_range(0, 39) == 0);
            clr_ovr      = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 699) == 0) mode = ~mode;
            rst          = ($urandom_range(0, 1499) == 0);
            sample_in    = 16'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; sample_valid = 1'b0; clr_ovr = 1'b0; cen = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_dac_multi.md
PWM_DAC_MULTI -- requirements
Module: pwm_dac_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning sample width in bits (signed, two's complement), legal range 4..16.
REQ-002 SHALL have parameter CHANNELS, default 2, meaning number of independent 1-bit DAC outputs, legal range 1..8.
REQ-003 SHALL have port clk, input, 1, the single clock for the whole block.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port cen, input, 1, clock enable: the counter and modulators advance only when cen=1.
REQ-006 SHALL have port mode, input, 1: 0 selects PWM, 1 selects first-order sigma-delta.
REQ-007 SHALL have port sample_in, input, CHANNELS*WIDTH, packed signed samples; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port sample_valid, input, 1, a one-cycle strobe that qualifies sample_in for all channels.
REQ-009 SHALL have port clr_ovr, input, 1, clears the overrun flag.
REQ-010 SHALL have port dac_out, output, CHANNELS, registered 1-bit output per channel.
REQ-011 SHALL have port period_start, output, 1, a one-cycle pulse in the cycle the new period's sample set becomes active.
REQ-012 SHALL have port overrun, output, 1, sticky flag set when a pending sample set is overwritten.

Function
REQ-013 SHALL convert each signed sample to offset binary: u = sample XOR (1 << (WIDTH-1)), so -2^(WIDTH-1) maps to 0 and 0 maps to 2^(WIDTH-1).
REQ-014 SHALL run a shared period counter cnt of WIDTH bits that increments on cen=1 and wraps from 2^WIDTH-1 to 0; the period is 2^WIDTH enabled cycles.
REQ-015 SHALL define the wrap cycle as the cycle with cen=1 and cnt=2^WIDTH-1.
REQ-016 SHALL double-buffer samples: sample_valid loads a pending register and sets pending_full; on the wrap cycle, active <= pending and pending_full <= 0.
REQ-017 SHALL, if sample_valid coincides with the wrap cycle, load sample_in directly into active, leave pending_full=0, and leave overrun unchanged.
REQ-018 SHALL, if sample_valid arrives while pending_full=1 and it is not the wrap cycle, overwrite pending and set overrun.
REQ-019 SHALL clear overrun on clr_ovr=1; if clr_ovr and a new overrun event occur in the same cycle, the set wins.
REQ-020 SHALL latch mode only on the wrap cycle; a mode change mid-period takes effect from the next period.
REQ-021 SHALL, in PWM mode, compute the next value of dac_out[k] as (cnt < u_k): u=0 gives a constant 0 and u=2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH cycles.
REQ-022 SHALL, in sigma-delta mode, use a per-channel accumulator of WIDTH+1 bits: on cen=1, acc <= {1'b0, acc[WIDTH-1:0]} + u_k, and the next value of dac_out[k] is the resulting acc[WIDTH].
REQ-023 SHALL clear all accumulators on the wrap cycle in which the latched mode changes.
REQ-024 SHALL hold dac_out, cnt and the accumulators while cen=0; sample_valid capture and clr_ovr SHALL still act while cen=0.
REQ-025 SHALL update dac_out one clk after the compare or accumulate cycle, giving a latency of one cycle from cnt to the pin.
REQ-026 SHALL assert period_start in the cycle immediately after the wrap cycle, for exactly one clk.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, set cnt=0, every active and pending sample to signed 0 (u=2^(WIDTH-1)), pending_full=0, accumulators=0, latched mode=0, dac_out=0, period_start=0 and overrun=0.
REQ-028 SHALL give rst priority over cen, sample_valid and clr_ovr; a reset mid-period SHALL discard the pending sample.

Structure
REQ-029 SHALL place the mode constants (PWM=0, SD=1) and the offset-binary conversion function in a shared package, pwm_dac_pkg.
REQ-030 SHALL implement the per-channel active register, comparator, accumulator and output flop in one sub-module, pwm_dac_ch, instantiated CHANNELS times; the counter, buffering and flags SHALL stay in the top level.

Verification (WIDTH=8, CHANNELS=2, cen=1 unless stated)
REQ-031 SHALL check reset: after rst, ch0 in PWM shows 128 high and 128 low cycles per 256, and overrun=0.
REQ-032 SHALL check PWM extremes: samples -128 and +127 -> ch0 constant 0, ch1 high for 255 of 256 cycles, with the update starting exactly at period_start.
REQ-033 SHALL check the overrun path: two sample_valid strobes within one period -> overrun=1, the second sample is applied at the wrap, and clr_ovr returns overrun to 0.
REQ-034 SHALL check the wrap coincidence: sample_valid on cnt=255 -> the sample is active in the next period and overrun stays 0.
REQ-035 SHALL check sigma-delta: sample +64 (u=192) -> exactly 192 ones per 256 cycles; mode toggled mid-period applies only after the next wrap, with the accumulator cleared.
REQ-036 SHALL check cen gating: cen toggling 1/0 -> the period stretches to 512 clk and dac_out holds during cen=0.
